ex_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register of the 5-stage core. Consumes the ID/EX register outputs and computes the ALU result, the branch target and the zero flag. It selects the destination register and registers everything into EX/MEM for the memory stage. R-type MUL runs on an iterative 32-cycle shift-add multiplier; while it runs, `stall` holds IF/ID/ID-EX upstream and bubbles go downstream.

---
 rtl/ex_stage.sv | 197 +++++++++++++++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage with iterative shift-add MUL and EX/MEM pipeline register
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] sign_ext,
  input  logic [4:0]  instr_2021,
  input  logic [4:0]  instr_1511,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  wb_ctl_q,
  output logic [2:0]  m_ctl_q,
  output logic [31:0] branch_target_q,
  output logic        zero_q,
  output logic [31:0] alu_result_q,
  output logic [31:0] rdata2_q,
  output logic [4:0]  dest_q
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [2:0] {
    FN_ADD = 3'd0, FN_SUB = 3'd1, FN_AND = 3'd2,
    FN_OR  = 3'd3, FN_SLT = 3'd4, FN_MUL = 3'd5
  } alu_fn_t;

  state_t      r_state;
  state_t      w_next_state;
  alu_fn_t     w_fn;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;

  logic [31:0] w_opb;
  logic [4:0]  w_dest;
  logic [31:0] w_branch_target;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_is_mul;
  logic        w_start;
  logic        w_step;
  logic        w_bubble;
  logic        w_use_acc;
  logic        w_stall;

  assign w_opb           = alusrc ? sign_ext : rdata2;
  assign w_dest          = regdst ? instr_1511 : instr_2021;
  assign w_branch_target = npc + (sign_ext << 2);
  assign w_is_mul        = (w_fn == FN_MUL);
  assign w_result        = w_use_acc ? r_acc : w_alu;
  assign stall           = w_stall;

  // ALU function decode from op class and funct field
  always_comb begin
    w_fn = FN_ADD;
    case (aluop)
      2'b01: w_fn = FN_SUB;
      2'b10: begin
        case (sign_ext[5:0])
          6'h22:   w_fn = FN_SUB;
          6'h24:   w_fn = FN_AND;
          6'h25:   w_fn = FN_OR;
          6'h2A:   w_fn = FN_SLT;
          6'h18:   w_fn = FN_MUL;
          default: w_fn = FN_ADD;
        endcase
      end
      default: w_fn = FN_ADD;
    endcase
  end

  // Single-cycle ALU; MUL results come from the iterative accumulator, never from here
  always_comb begin
    w_alu = rdata1 + w_opb;
    case (w_fn)
      FN_SUB:  w_alu = rdata1 - w_opb;
      FN_AND:  w_alu = rdata1 & w_opb;
      FN_OR:   w_alu = rdata1 | w_opb;
      FN_SLT:  w_alu = {31'd0, $signed(rdata1) < $signed(w_opb)};
      FN_MUL:  w_alu = 32'd0;
      default: w_alu = rdata1 + w_opb;
    endcase
  end

  // Next state, stall and EX/MEM load selection; flush overrides everything
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    w_use_acc    = 1'b0;
    w_start      = 1'b0;
    w_step       = 1'b0;
    if (flush) begin
      w_next_state = IDLE;
      w_bubble     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mul) begin
            w_start      = 1'b1;
            w_stall      = 1'b1;
            w_bubble     = 1'b1;
            w_next_state = BUSY;
          end
        end
        BUSY: begin
          w_step   = 1'b1;
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (r_cnt == 5'd31) begin
            w_next_state = DONE;
          end
        end
        DONE: begin
          w_use_acc    = 1'b1;
          w_next_state = IDLE;
        end
        default: begin
          w_bubble     = 1'b1;
          w_next_state = IDLE;
        end
      endcase
    end
    // stall must never hold upstream while the core is in reset
    if (!reset) begin
      w_stall = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shift-add multiplier: latch operands on issue, one partial product per BUSY cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 5'd0;
    end else if (w_start) begin
      r_mcand  <= rdata1;
      r_mplier <= w_opb;
      r_acc    <= 32'd0;
      r_cnt    <= 5'd0;
    end else if (w_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  // EX/MEM pipeline register; bubbles clear control, destination and data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_ctl_q        <= 2'd0;
      m_ctl_q         <= 3'd0;
      branch_target_q <= 32'd0;
      zero_q          <= 1'b0;
      alu_result_q    <= 32'd0;
      rdata2_q        <= 32'd0;
      dest_q          <= 5'd0;
    end else if (w_bubble) begin
      wb_ctl_q        <= 2'd0;
      m_ctl_q         <= 3'd0;
      branch_target_q <= 32'd0;
      zero_q          <= 1'b0;
      alu_result_q    <= 32'd0;
      rdata2_q        <= 32'd0;
      dest_q          <= 5'd0;
    end else begin
      wb_ctl_q        <= wb_ctl;
      m_ctl_q         <= m_ctl;
      branch_target_q <= w_branch_target;
      zero_q          <= (w_result == 32'd0);
      alu_result_q    <= w_result;
      rdata2_q        <= rdata2;
      dest_q          <= w_dest;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage
module tb_ex_stage;

  logic        clock;
  logic        reset;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] sign_ext;
  logic [4:0]  instr_2021;
  logic [4:0]  instr_1511;
  logic        flush;
  logic        stall;
  logic [1:0]  wb_ctl_q;
  logic [2:0]  m_ctl_q;
  logic [31:0] branch_target_q;
  logic        zero_q;
  logic [31:0] alu_result_q;
  logic [31:0] rdata2_q;
  logic [4:0]  dest_q;

  ex_stage dut (
    .clock(clock), .reset(reset), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc),
    .rdata1(rdata1), .rdata2(rdata2), .sign_ext(sign_ext),
    .instr_2021(instr_2021), .instr_1511(instr_1511), .flush(flush),
    .stall(stall), .wb_ctl_q(wb_ctl_q), .m_ctl_q(m_ctl_q),
    .branch_target_q(branch_target_q), .zero_q(zero_q),
    .alu_result_q(alu_result_q), .rdata2_q(rdata2_q), .dest_q(dest_q)
  );

  typedef struct {
    string       name;
    logic        bub;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] bt;
    logic        z;
    logic [31:0] res;
    logic [31:0] rd2;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(string n, logic [1:0] wb, logic [2:0] m, logic [31:0] bt,
                              logic [31:0] res, logic [31:0] rd2, logic [4:0] dest);
    exp_t e;
    e.name = n; e.bub = 1'b0; e.wb = wb; e.m = m; e.bt = bt;
    e.z = (res == 32'd0); e.res = res; e.rd2 = rd2; e.dest = dest;
    return e;
  endfunction

  function automatic exp_t bubble(string n);
    exp_t e;
    e.name = n; e.bub = 1'b1; e.wb = 2'd0; e.m = 3'd0; e.bt = 32'd0;
    e.z = 1'b0; e.res = 32'd0; e.rd2 = 32'd0; e.dest = 5'd0;
    return e;
  endfunction

  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic check_all_zero(string n);
    chk(n, {21'd0, wb_ctl_q, m_ctl_q, branch_target_q, zero_q, alu_result_q, rdata2_q, dest_q}, 128'd0);
  endtask

  task automatic drive(logic [1:0] wb, logic [2:0] m, logic rd, logic as, logic [1:0] op,
                       logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] se,
                       logic [4:0] i20, logic [4:0] i15);
    wb_ctl = wb; m_ctl = m; regdst = rd; alusrc = as; aluop = op; npc = pc;
    rdata1 = a; rdata2 = b; sign_ext = se; instr_2021 = i20; instr_1511 = i15;
  endtask

  // One clock: queue the EX/MEM content expected after the next rising edge
  task automatic step(exp_t e);
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Monitor: EX/MEM is written on every edge out of reset; compare against the queue head
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.bub ? (wb_ctl_q !== 2'd0 || m_ctl_q !== 3'd0 || dest_q !== 5'd0)
                    : (wb_ctl_q !== mon_e.wb || m_ctl_q !== mon_e.m ||
                       branch_target_q !== mon_e.bt || zero_q !== mon_e.z ||
                       alu_result_q !== mon_e.res || rdata2_q !== mon_e.rd2 ||
                       dest_q !== mon_e.dest)) begin
        failures++;
        $display("FAIL %s actual wb=%0h m=%0h bt=%0h z=%0b res=%0h rd2=%0h dest=%0d required bub=%0b wb=%0h m=%0h bt=%0h z=%0b res=%0h rd2=%0h dest=%0d",
                 mon_e.name, wb_ctl_q, m_ctl_q, branch_target_q, zero_q, alu_result_q, rdata2_q, dest_q,
                 mon_e.bub, mon_e.wb, mon_e.m, mon_e.bt, mon_e.z, mon_e.res, mon_e.rd2, mon_e.dest);
      end
    end
  end

  // Issue a MUL held under stall; expect 33 stalled bubbles then the product
  task automatic run_mul(string n, logic [31:0] a, logic [31:0] b, logic [31:0] pc,
                         logic [31:0] bt, logic [31:0] prod);
    int hi;
    hi = 0;
    drive(2'b11, 3'b010, 1'b1, 1'b0, 2'b10, pc, a, b, 32'h18, 5'd3, 5'd17);
    for (int i = 0; i < 33; i++) begin
      #1;
      if (stall === 1'b1) hi++;
      step(bubble({n, "_bubble"}));
    end
    chk({n, "_stall_cycles"}, hi, 33);
    #1;
    chk({n, "_done_stall"}, stall, 0);
    step(mk({n, "_result"}, 2'b11, 3'b010, bt, prod, b, 5'd17));
  endtask

  initial begin
    int to;
    reset = 1'b0;
    flush = 1'b0;
    drive(2'b11, 3'b111, 1'b1, 1'b0, 2'b10, 32'h44, 32'h10001, 32'h30003, 32'h18, 5'd5, 5'd6);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_outputs");
    chk("reset_stall", stall, 0);

    reset = 1'b1;
    drive(2'b10, 3'b001, 1'b0, 1'b0, 2'b00, 32'h40, 32'd5, 32'd7, 32'h10, 5'd4, 5'd0);
    step(mk("add_5_7", 2'b10, 3'b001, 32'h80, 32'd12, 32'd7, 5'd4));

    drive(2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd3, 32'd3, 32'h22, 5'd2, 5'd9);
    step(mk("rtype_sub_zero", 2'b01, 3'b000, 32'h88, 32'd0, 32'd3, 5'd9));
    drive(2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd2, 5'd9);
    step(mk("rtype_slt_neg", 2'b01, 3'b000, 32'hA8, 32'd1, 32'd1, 5'd9));
    drive(2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd2, 5'd10);
    step(mk("rtype_and", 2'b01, 3'b000, 32'h90, 32'hF000, 32'hFF00, 5'd10));
    drive(2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 32'h25, 5'd2, 5'd11);
    step(mk("rtype_or", 2'b01, 3'b000, 32'h94, 32'hFFF0, 32'hFF00, 5'd11));
    drive(2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h8, 32'd2, 32'd3, 32'h3F, 5'd2, 5'd12);
    step(mk("rtype_unknown_add", 2'b01, 3'b000, 32'h104, 32'd5, 32'd3, 5'd12));

    drive(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'd8, 32'd8, 32'hFFFFFFFE, 5'd0, 5'd1);
    step(mk("branch_target", 2'b00, 3'b100, 32'hF8, 32'd0, 32'd8, 5'd0));
    drive(2'b10, 3'b001, 1'b0, 1'b0, 2'b01, 32'h0, 32'd0, 32'd1, 32'h0, 5'd3, 5'd1);
    step(mk("sub_wrap", 2'b10, 3'b001, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd3));
    drive(2'b10, 3'b001, 1'b0, 1'b1, 2'b00, 32'h20, 32'd10, 32'h55, 32'hFFFFFFFF, 5'd7, 5'd1);
    step(mk("addi_neg_imm", 2'b10, 3'b001, 32'h1C, 32'd9, 32'h55, 5'd7));

    run_mul("mul_a", 32'h10001, 32'h30003, 32'h200, 32'h260, 32'h00060003);
    run_mul("mul_b2b", 32'd7, 32'd6, 32'h204, 32'h264, 32'd42);

    // flush on cycle 10 of a MUL
    drive(2'b11, 3'b010, 1'b1, 1'b0, 2'b10, 32'h200, 32'd9, 32'd9, 32'h18, 5'd3, 5'd17);
    for (int i = 0; i < 9; i++) begin
      step(bubble("flush_mul_bubble"));
    end
    #1;
    chk("flush_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("flush_stall_drop", stall, 0);
    step(bubble("flush_bubble"));
    flush = 1'b0;
    drive(2'b01, 3'b011, 1'b0, 1'b0, 2'b00, 32'h300, 32'd1, 32'd1, 32'h0, 5'd8, 5'd1);
    #1;
    chk("after_flush_stall", stall, 0);
    step(mk("after_flush_add", 2'b01, 3'b011, 32'h300, 32'd2, 32'd1, 5'd8));

    // async reset clears a live result without a clock edge
    drive(2'b01, 3'b001, 1'b0, 1'b0, 2'b00, 32'h10, 32'd20, 32'd22, 32'd4, 5'd13, 5'd1);
    step(mk("add_42", 2'b01, 3'b001, 32'h20, 32'd42, 32'd22, 5'd13));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_clear_result");
    @(negedge clock);
    reset = 1'b1;

    // async reset in the middle of a MUL
    drive(2'b11, 3'b010, 1'b1, 1'b0, 2'b10, 32'h200, 32'd5, 32'd5, 32'h18, 5'd3, 5'd17);
    for (int i = 0; i < 5; i++) begin
      step(bubble("rst_mul_bubble"));
    end
    #2;
    chk("rst_mul_pre_stall", stall, 1);
    reset = 1'b0;
    #1;
    chk("rst_mul_stall", stall, 0);
    check_all_zero("rst_mul_outputs");
    @(negedge clock);
    drive(2'b10, 3'b110, 1'b0, 1'b0, 2'b00, 32'h0, 32'd3, 32'd4, 32'h0, 5'd21, 5'd1);
    reset = 1'b1;
    #1;
    chk("rst_release_stall", stall, 0);
    step(mk("rst_release_add", 2'b10, 3'b110, 32'h0, 32'd7, 32'd4, 5'd21));

    to = 0;
    while (sb.size() > 0 && to < 10) begin
      @(posedge clock);
      to++;
    end
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
